// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg : shared types/constants for the serial CLA add/sub controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Counter width for n chunks; never below one bit so NUM_CHUNKS==1 still has a register.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/carry_lookahead_unit_adder.sv
// ---------------------------------------------------------------------------
// carry_lookahead_unit_adder : DATA_IN_W-bit CLA slice with group P/G. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module carry_lookahead_unit_adder #(
  parameter int DATA_IN_W = 4
) (
  input  logic [DATA_IN_W-1:0] a_i,
  input  logic [DATA_IN_W-1:0] b_i,
  input  logic                 c_i,
  output logic [DATA_IN_W-1:0] sum_o,
  output logic                 c_o,
  output logic                 pg_o,
  output logic                 gg_o
);

  logic [DATA_IN_W-1:0] w_g;
  logic [DATA_IN_W-1:0] w_p;
  logic [DATA_IN_W:0]   w_c;

  assign w_g = a_i & b_i;
  assign w_p = a_i ^ b_i;

  // Each carry is the prefix group generate/propagate over bits [i:0] applied to c_i.
  always_comb begin : p_lookahead
    logic w_gacc;
    logic w_pacc;
    w_gacc = 1'b0;
    w_pacc = 1'b1;
    w_c    = '0;
    w_c[0] = c_i;
    for (int i = 0; i < DATA_IN_W; i++) begin
      w_gacc     = w_g[i] | (w_p[i] & w_gacc);
      w_pacc     = w_p[i] & w_pacc;
      w_c[i + 1] = w_gacc | (w_pacc & c_i);
    end
    gg_o = w_gacc;
    pg_o = w_pacc;
  end

  assign sum_o = w_p ^ w_c[DATA_IN_W-1:0];
  assign c_o   = w_c[DATA_IN_W];

endmodule

`default_nettype wire

// File: rtl/cla_serial_add_sub_ctrl.sv
// ---------------------------------------------------------------------------
// cla_serial_add_sub_ctrl : DATA_W signed add/sub over one shared CLA slice,
// LSB chunk first, with valid/ready on both sides. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cla_serial_add_sub_ctrl
  import cla_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              op_sub_i,
  input  logic [DATA_W-1:0] inp_A_i,
  input  logic [DATA_W-1:0] inp_B_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int CNT_W      = cnt_width(NUM_CHUNKS);

  generate
    if ((DATA_W % CHUNK_W) != 0 || NUM_CHUNKS < 1) begin : g_bad_width
      $error("DATA_W must be a non-zero multiple of CHUNK_W");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic [CHUNK_W-1:0]  w_a_chunk;
  logic [CHUNK_W-1:0]  w_b_chunk;
  logic [CHUNK_W-1:0]  w_sum;
  logic                w_cout;
  logic                w_last;
  logic                unused_pg;
  logic                unused_gg;

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        w_a_chunk = a_q[k*CHUNK_W +: CHUNK_W];
        w_b_chunk = b_q[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  carry_lookahead_unit_adder #(
    .DATA_IN_W (CHUNK_W)
  ) u_slice (
    .a_i   (w_a_chunk),
    .b_i   (w_b_chunk),
    .c_i   (carry_q),
    .sum_o (w_sum),
    .c_o   (w_cout),
    .pg_o  (unused_pg),
    .gg_o  (unused_gg)
  );

  assign w_last = (cnt_q == CNT_W'(NUM_CHUNKS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d     = inp_A_i;
          b_d     = (op_sub_i == OP_ADD) ? inp_B_i : ~inp_B_i;
          carry_d = (op_sub_i == OP_SUB);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < NUM_CHUNKS; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            res_d[k*CHUNK_W +: CHUNK_W] = w_sum;
          end
        end
        carry_d = w_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (w_last) begin
          // b_q already holds ~B for subtract, so this is the usual same-sign rule.
          cout_d  = w_cout;
          ovf_d   = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                    (w_sum[CHUNK_W-1] != a_q[DATA_W-1]);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign result_o    = res_q;
  assign carry_o     = cout_q;
  assign overflow_o  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_serial_add_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cla_serial_add_sub_ctrl : scoreboard bench, DATA_W=16 / CHUNK_W=4. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cla_serial_add_sub_ctrl;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int NC = DW / CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          op_sub;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          carry;
  logic          ovf;
  logic          busy;

  cla_serial_add_sub_ctrl #(
    .DATA_W  (DW),
    .CHUNK_W (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_sub_i    (op_sub),
    .inp_A_i     (a_in),
    .inp_B_i     (b_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .carry_o     (carry),
    .overflow_o  (ovf),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic          c;
    logic          v;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Independent reference: unsigned compare/sum for carry, integer range for overflow.
  task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sub,
                       output logic [DW-1:0] r, output logic c, output logic v);
    int sa, sb, t;
    int ua, ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    t  = sub ? (sa - sb) : (sa + sb);
    v  = (t > 32767) || (t < -32768);
    if (sub) begin
      r = DW'(ua - ub);
      c = (ua >= ub);
    end else begin
      r = DW'(ua + ub);
      c = ((ua + ub) > 65535);
    end
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sub,
                      input logic [DW-1:0] er, input logic ec, input logic ev);
    exp_t e;
    int n;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    op_sub   = sub;
    n        = 0;
    forever begin
      if (in_ready) begin
        e.res = er;
        e.c   = ec;
        e.v   = ev;
        e.acc = cyc;
        q.push_back(e);
        tick();
        break;
      end
      tick();
      n++;
      if (n > 100) begin
        chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    a_in     = DW'($urandom);
    b_in     = DW'($urandom);
    op_sub   = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("orphan_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - q[0].acc, NC + 1);
          seen = 1'b1;
        end
        chk("result", {16'b0, result}, {16'b0, q[0].res});
        chk("carry", {31'b0, carry}, {31'b0, q[0].c});
        chk("overflow", {31'b0, ovf}, {31'b0, q[0].v});
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] ra, rb, rr;
    logic          rc, rv;
    bit            rs;
    int            n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_carry", {31'b0, carry}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b0;
    tick();

    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain();
    send(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b1);
    drain();

    // Backpressure: result must hold and new operands stay unaccepted.
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_reach_done", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b1;
    a_in     = 16'hAAAA;
    b_in     = 16'h1111;
    op_sub   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold", {16'b0, result}, 32'h2345);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'b0, out_valid}, 32'd0);
    send(16'hAAAA, 16'h1111, 1'b1, 16'h9999, 1'b1, 1'b0);
    drain();

    // Asynchronous reset while the counter sits at chunk 2.
    send(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_result", {16'b0, result}, 32'd0);
    chk("arst_carry", {31'b0, carry}, 32'd0);
    chk("arst_ovf", {31'b0, ovf}, 32'd0);
    q.delete();
    seen = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("arst_no_valid", {31'b0, out_valid}, 32'd0);
    end
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ra = DW'($urandom);
      rb = DW'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'h8000;
        1: rb = 16'h8000;
        2: rb = 16'hFFFF;
        default: ;
      endcase
      rs = 1'($urandom);
      model(ra, rb, rs, rr, rc, rv);
      send(ra, rb, rs, rr, rc, rv);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("final_queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
